regfile_wb_arbiter: RTL and testbench

Controller for the 32x32 processor register file.
- Merges two writeback sources, the ALU result and the memory load data, onto the register file's single write port (RegWrite / MemtoReg / Write_register / Write_data).
- Keeps a per-register pending scoreboard that stalls issue on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - issue, writeback request and register file write port bundle
interface regfile_wb_arbiter_if;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        stall;

  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_ready;

  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;

  logic        RegWrite;
  logic        MemtoReg;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        spurious_wb;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output alu_valid, alu_rd, alu_result,
    output mem_valid, mem_rd, mem_data,
    input  stall, alu_ready, mem_ready,
    input  RegWrite, MemtoReg, Write_register, Write_data, spurious_wb
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  alu_valid, alu_rd, alu_result,
    input  mem_valid, mem_rd, mem_data,
    output stall, alu_ready, mem_ready,
    output RegWrite, MemtoReg, Write_register, Write_data, spurious_wb
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file writeback arbiter with pending-register scoreboard
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave rf
);
  localparam logic [0:0] MEM_PRIO = 1'b0;
  localparam logic [0:0] ALU_PRIO = 1'b1;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic [0:0]  state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic [31:0] pending, set_mask, clr_mask;
  logic        alu_grant, mem_grant, wb_live;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        reg_write_q, memtoreg_q, spurious_q;
  logic [4:0]  write_reg_q;
  logic [31:0] write_data_q;

  // Hazard check sees only the registered scoreboard; a same-cycle commit does not release it.
  assign rf.stall = rf.issue_valid & (pending[rf.issue_rs1] | pending[rf.issue_rs2] |
                                      ((rf.issue_rd != 5'd0) & pending[rf.issue_rd]));

  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (state == ALU_PRIO) begin
      alu_grant = rf.alu_valid;
      mem_grant = rf.mem_valid & ~rf.alu_valid;
    end else begin
      mem_grant = rf.mem_valid;
      alu_grant = rf.alu_valid & ~rf.mem_valid;
    end
  end

  assign rf.alu_ready = alu_grant;
  assign rf.mem_ready = mem_grant;

  always_comb begin
    starve_nxt = starve_cnt;
    state_nxt  = state;
    if (alu_grant) begin
      starve_nxt = 4'd0;
      state_nxt  = MEM_PRIO;
    end else begin
      if (rf.alu_valid && starve_cnt != LIMIT)
        starve_nxt = starve_cnt + 4'd1;
      if (starve_nxt == LIMIT)
        state_nxt = ALU_PRIO;
    end
  end

  assign wb_rd   = mem_grant ? rf.mem_rd : rf.alu_rd;
  assign wb_data = mem_grant ? rf.mem_data : rf.alu_result;
  // rd = 0 grants are consumed without touching the write port or scoreboard.
  assign wb_live = (alu_grant | mem_grant) & (wb_rd != 5'd0);

  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (rf.issue_valid && !rf.stall && rf.issue_rd != 5'd0)
      set_mask = 32'd1 << rf.issue_rd;
    if (reg_write_q)
      clr_mask = 32'd1 << write_reg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= MEM_PRIO;
      starve_cnt   <= 4'd0;
      pending      <= 32'd0;
      reg_write_q  <= 1'b0;
      memtoreg_q   <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      spurious_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_nxt;
      pending     <= (pending & ~clr_mask) | set_mask;
      reg_write_q <= wb_live;
      if (wb_live) begin
        memtoreg_q   <= mem_grant;
        write_reg_q  <= wb_rd;
        write_data_q <= wb_data;
        if (!pending[wb_rd])
          spurious_q <= 1'b1;
      end
    end
  end

  assign rf.RegWrite       = reg_write_q;
  assign rf.MemtoReg       = memtoreg_q;
  assign rf.Write_register = write_reg_q;
  assign rf.Write_data     = write_data_q;
  assign rf.spurious_wb    = spurious_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 3;

  typedef struct {
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  wb_t  exp_q[$];
  wb_t  mon_e;

  regfile_wb_arbiter_if ifc ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (ifc)
  );

  always #5 clk = ~clk;

  // Every registered write must match the oldest expected grant.
  always @(posedge clk) begin
    #2;
    if (ifc.RegWrite === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got reg=%0d data=%h, required no write", ifc.Write_register, ifc.Write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ifc.MemtoReg, ifc.Write_register, ifc.Write_data} !== {mon_e.m2r, mon_e.rd, mon_e.data}) begin
          fails++;
          $display("FAIL wb_write: got m2r=%0b reg=%0d data=%h, required m2r=%0b reg=%0d data=%h",
                   ifc.MemtoReg, ifc.Write_register, ifc.Write_data, mon_e.m2r, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ifc.issue_valid = 1'b0; ifc.issue_rs1 = 5'd0; ifc.issue_rs2 = 5'd0; ifc.issue_rd = 5'd0;
    ifc.alu_valid = 1'b0; ifc.alu_rd = 5'd0; ifc.alu_result = 32'd0;
    ifc.mem_valid = 1'b0; ifc.mem_rd = 5'd0; ifc.mem_data = 32'd0;
  endtask

  task automatic issue(input logic [4:0] rd);
    ifc.issue_valid = 1'b1; ifc.issue_rs1 = 5'd0; ifc.issue_rs2 = 5'd0; ifc.issue_rd = rd;
    @(negedge clk);
    ifc.issue_valid = 1'b0;
  endtask

  // Reads pending[r] through stall without setting anything (rd = 0).
  task automatic probe(input logic [4:0] r, output logic s);
    ifc.issue_valid = 1'b1; ifc.issue_rs1 = r; ifc.issue_rs2 = 5'd0; ifc.issue_rd = 5'd0;
    #1 s = ifc.stall;
    @(negedge clk);
    ifc.issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    tests++;
    if ({ifc.RegWrite, ifc.MemtoReg, ifc.Write_register, ifc.Write_data, ifc.spurious_wb} !== 40'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0",
               {ifc.RegWrite, ifc.MemtoReg, ifc.Write_register, ifc.Write_data, ifc.spurious_wb});
    end
    reset = 1'b0;
  endtask

  task automatic test_raw();
    ifc.issue_valid = 1'b1; ifc.issue_rs1 = 5'd1; ifc.issue_rs2 = 5'd2; ifc.issue_rd = 5'd5;
    #1 tests++;
    if (ifc.stall !== 1'b0) begin fails++; $display("FAIL raw_first_issue: got stall=%b, required 0", ifc.stall); end
    @(negedge clk);
    ifc.issue_rs1 = 5'd5; ifc.issue_rs2 = 5'd0; ifc.issue_rd = 5'd0;
    ifc.alu_valid = 1'b1; ifc.alu_rd = 5'd5; ifc.alu_result = 32'h0000_00AA;
    exp_q.push_back('{1'b0, 5'd5, 32'h0000_00AA});
    #1 tests++;
    if ({ifc.stall, ifc.alu_ready} !== 2'b11) begin
      fails++; $display("FAIL raw_stall_grant: got stall=%b alu_ready=%b, required 1 1", ifc.stall, ifc.alu_ready);
    end
    @(negedge clk);
    ifc.alu_valid = 1'b0;
    #1 tests++;
    if ({ifc.stall, ifc.RegWrite, ifc.MemtoReg} !== 3'b110) begin
      fails++; $display("FAIL raw_commit_cycle: got stall=%b RegWrite=%b MemtoReg=%b, required 1 1 0",
                        ifc.stall, ifc.RegWrite, ifc.MemtoReg);
    end
    @(negedge clk);
    #1 tests++;
    if (ifc.stall !== 1'b0) begin fails++; $display("FAIL raw_release: got stall=%b, required 0", ifc.stall); end
    ifc.issue_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_both_valid();
    issue(5'd3);
    issue(5'd4);
    ifc.issue_valid = 1'b1; ifc.issue_rs1 = 5'd0; ifc.issue_rs2 = 5'd0; ifc.issue_rd = 5'd3;
    #1 tests++;
    if (ifc.stall !== 1'b1) begin fails++; $display("FAIL waw_stall: got stall=%b, required 1", ifc.stall); end
    @(negedge clk);
    ifc.issue_valid = 1'b0;
    ifc.alu_valid = 1'b1; ifc.alu_rd = 5'd3; ifc.alu_result = 32'h33;
    ifc.mem_valid = 1'b1; ifc.mem_rd = 5'd4; ifc.mem_data = 32'h44;
    exp_q.push_back('{1'b1, 5'd4, 32'h44});
    #1 tests++;
    if ({ifc.mem_ready, ifc.alu_ready} !== 2'b10) begin
      fails++; $display("FAIL both_mem_first: got mem_ready=%b alu_ready=%b, required 1 0", ifc.mem_ready, ifc.alu_ready);
    end
    @(negedge clk);
    ifc.mem_valid = 1'b0;
    exp_q.push_back('{1'b0, 5'd3, 32'h33});
    #1 tests++;
    if ({ifc.mem_ready, ifc.alu_ready} !== 2'b01) begin
      fails++; $display("FAIL both_alu_second: got mem_ready=%b alu_ready=%b, required 0 1", ifc.mem_ready, ifc.alu_ready);
    end
    @(negedge clk);
    ifc.alu_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starve();
    int m = 0;
    for (int r = 10; r < 14; r++) issue(5'(r));
    issue(5'd15);
    ifc.alu_rd = 5'd15; ifc.alu_result = 32'h1515;
    for (int c = 0; c < LIMIT + 2; c++) begin
      ifc.mem_valid = 1'b1; ifc.mem_rd = 5'(10 + m); ifc.mem_data = 32'h100 + 32'(m);
      ifc.alu_valid = (c <= LIMIT);
      if (c == LIMIT) exp_q.push_back('{1'b0, 5'd15, 32'h1515});
      else exp_q.push_back('{1'b1, 5'(10 + m), 32'h100 + 32'(m)});
      #1 tests++;
      if ({ifc.alu_ready, ifc.mem_ready} !== ((c == LIMIT) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL starve_cycle%0d: got alu_ready=%b mem_ready=%b, required %0d", c,
                          ifc.alu_ready, ifc.mem_ready, (c == LIMIT) ? 2 : 1);
      end
      if (c != LIMIT) m++;
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_rd_zero();
    logic s;
    issue(5'd0);
    ifc.alu_valid = 1'b1; ifc.alu_rd = 5'd0; ifc.alu_result = 32'hDEAD;
    #1 tests++;
    if (ifc.alu_ready !== 1'b1) begin fails++; $display("FAIL rd0_ready: got %b, required 1", ifc.alu_ready); end
    @(negedge clk);
    ifc.alu_valid = 1'b0;
    tests++;
    if ({ifc.RegWrite, ifc.spurious_wb} !== 2'b00) begin
      fails++; $display("FAIL rd0_no_write: got RegWrite=%b spurious=%b, required 0 0", ifc.RegWrite, ifc.spurious_wb);
    end
    for (int r = 0; r < 32; r++) begin
      probe(5'(r), s);
      tests++;
      if (s !== 1'b0) begin fails++; $display("FAIL rd0_pending%0d: got stall=%b, required 0", r, s); end
    end
  endtask

  task automatic test_spurious();
    ifc.alu_valid = 1'b1; ifc.alu_rd = 5'd7; ifc.alu_result = 32'h77;
    exp_q.push_back('{1'b0, 5'd7, 32'h77});
    @(negedge clk);
    ifc.alu_valid = 1'b0;
    tests++;
    if ({ifc.spurious_wb, ifc.RegWrite, ifc.Write_register} !== {1'b1, 1'b1, 5'd7}) begin
      fails++; $display("FAIL spurious_set: got spurious=%b RegWrite=%b reg=%0d, required 1 1 7",
                        ifc.spurious_wb, ifc.RegWrite, ifc.Write_register);
    end
    issue(5'd8);
    ifc.mem_valid = 1'b1; ifc.mem_rd = 5'd8; ifc.mem_data = 32'h88;
    exp_q.push_back('{1'b1, 5'd8, 32'h88});
    @(negedge clk);
    ifc.mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (ifc.spurious_wb !== 1'b1) begin fails++; $display("FAIL spurious_sticky: got %b, required 1", ifc.spurious_wb); end
  endtask

  task automatic test_reset_mid();
    logic s;
    issue(5'd9);
    issue(5'd25);
    ifc.alu_valid = 1'b1; ifc.alu_rd = 5'd21; ifc.alu_result = 32'h21;
    ifc.mem_valid = 1'b1; ifc.mem_rd = 5'd9; ifc.mem_data = 32'h99;
    exp_q.push_back('{1'b1, 5'd9, 32'h99});
    @(negedge clk);
    ifc.mem_rd = 5'd23; ifc.mem_data = 32'h23;
    exp_q.push_back('{1'b1, 5'd23, 32'h23});
    @(negedge clk);
    reset = 1'b1;
    ifc.mem_rd = 5'd24; ifc.mem_data = 32'h24;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    tests++;
    if ({ifc.RegWrite, ifc.spurious_wb} !== 2'b00) begin
      fails++; $display("FAIL mid_reset_out: got RegWrite=%b spurious=%b, required 0 0", ifc.RegWrite, ifc.spurious_wb);
    end
    foreach (exp_q[i]) begin end
    for (int r = 0; r < 32; r++) begin
      probe(5'(r), s);
      tests++;
      if (s !== 1'b0) begin fails++; $display("FAIL mid_pending%0d: got stall=%b, required 0", r, s); end
    end
    ifc.alu_rd = 5'd27; ifc.alu_result = 32'h2727;
    for (int c = 0; c < LIMIT + 1; c++) begin
      ifc.mem_valid = 1'b1; ifc.mem_rd = 5'(28 + c); ifc.mem_data = 32'h280 + 32'(c);
      ifc.alu_valid = 1'b1;
      if (c == LIMIT) exp_q.push_back('{1'b0, 5'd27, 32'h2727});
      else exp_q.push_back('{1'b1, 5'(28 + c), 32'h280 + 32'(c)});
      #1 tests++;
      if ({ifc.alu_ready, ifc.mem_ready} !== ((c == LIMIT) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL mid_counter%0d: got alu_ready=%b mem_ready=%b, required %0d", c,
                          ifc.alu_ready, ifc.mem_ready, (c == LIMIT) ? 2 : 1);
      end
      @(negedge clk);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_raw();
    test_both_valid();
    test_starve();
    test_rd_zero();
    test_spurious();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL wb_missing: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
